// File: rtl/edge_bbox_stats.sv
// edge_bbox_stats: per-frame edge pixel count and bounding box of a binary edge stream.
// The video stream is forwarded with a 1-clk delay.
// Optional build macro EDGE_BBOX_OVERLAY_EN draws the last reported box onto post_img_Bit.
module edge_bbox_stats #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_img_Bit,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_img_Bit,
  output logic        stat_valid,
  output logic        stat_found,
  output logic [10:0] stat_xmin,
  output logic [10:0] stat_xmax,
  output logic [10:0] stat_ymin,
  output logic [10:0] stat_ymax,
  output logic [20:0] stat_count
);

  localparam int unsigned CW   = 11;
  localparam int unsigned CNTW = 21;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    REPORT     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            vsync_prev_q, vsync_prev_d;
  logic            post_vsync_q, post_vsync_d;
  logic            post_href_q, post_href_d;
  logic            post_bit_q, post_bit_d;
  logic [CW-1:0]   hcnt_q, hcnt_d;
  logic [CW-1:0]   vcnt_q, vcnt_d;
  logic            acc_found_q, acc_found_d;
  logic [CW-1:0]   acc_xmin_q, acc_xmin_d;
  logic [CW-1:0]   acc_xmax_q, acc_xmax_d;
  logic [CW-1:0]   acc_ymin_q, acc_ymin_d;
  logic [CW-1:0]   acc_ymax_q, acc_ymax_d;
  logic [CNTW-1:0] acc_count_q, acc_count_d;
  logic            stat_valid_q, stat_valid_d;
  logic            stat_found_q, stat_found_d;
  logic [CW-1:0]   stat_xmin_q, stat_xmin_d;
  logic [CW-1:0]   stat_xmax_q, stat_xmax_d;
  logic [CW-1:0]   stat_ymin_q, stat_ymin_d;
  logic [CW-1:0]   stat_ymax_q, stat_ymax_d;
  logic [CNTW-1:0] stat_count_q, stat_count_d;

  logic frame_start, frame_end, href_fall, accept, edge_hit;

  assign frame_start = per_frame_vsync & ~vsync_prev_q;
  assign frame_end   = ~per_frame_vsync & vsync_prev_q;
  assign href_fall   = ~per_frame_href & post_href_q;
  assign accept      = (state_q == ACTIVE) & per_frame_vsync & per_frame_href;
  assign edge_hit    = accept & per_img_Bit & (hcnt_q < IMG_HDISP) & (vcnt_q < IMG_VDISP);

  // Video path: 1-clk delay, bit gated by href, optional box overlay
  always_comb begin
    vsync_prev_d = per_frame_vsync;
    post_vsync_d = per_frame_vsync;
    post_href_d  = per_frame_href;
`ifdef EDGE_BBOX_OVERLAY_EN
    post_bit_d   = (per_img_Bit & per_frame_href) |
                   (accept & stat_found_q &
                    (((hcnt_q >= stat_xmin_q) & (hcnt_q <= stat_xmax_q) &
                      ((vcnt_q == stat_ymin_q) | (vcnt_q == stat_ymax_q))) |
                     ((vcnt_q >= stat_ymin_q) & (vcnt_q <= stat_ymax_q) &
                      ((hcnt_q == stat_xmin_q) | (hcnt_q == stat_xmax_q)))));
`else
    post_bit_d   = per_img_Bit & per_frame_href;
`endif
  end

  // Frame FSM, pixel coordinate counters, accumulators and result latch
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    acc_found_d  = acc_found_q;
    acc_xmin_d   = acc_xmin_q;
    acc_xmax_d   = acc_xmax_q;
    acc_ymin_d   = acc_ymin_q;
    acc_ymax_d   = acc_ymax_q;
    acc_count_d  = acc_count_q;
    stat_valid_d = 1'b0;
    stat_found_d = stat_found_q;
    stat_xmin_d  = stat_xmin_q;
    stat_xmax_d  = stat_xmax_q;
    stat_ymin_d  = stat_ymin_q;
    stat_ymax_d  = stat_ymax_q;
    stat_count_d = stat_count_q;

    case (state_q)
      WAIT_FRAME: begin
        if (frame_start) begin
          state_d     = ACTIVE;
          hcnt_d      = '0;
          vcnt_d      = '0;
          acc_found_d = 1'b0;
          acc_xmin_d  = '0;
          acc_xmax_d  = '0;
          acc_ymin_d  = '0;
          acc_ymax_d  = '0;
          acc_count_d = '0;
        end
      end
      ACTIVE: begin
        if (accept && (hcnt_q != IMG_HDISP)) begin
          hcnt_d = hcnt_q + CW'(1);
        end
        if (href_fall) begin
          hcnt_d = '0;
          if (vcnt_q != IMG_VDISP) begin
            vcnt_d = vcnt_q + CW'(1);
          end
        end
        if (edge_hit) begin
          acc_found_d = 1'b1;
          if (!acc_found_q) begin
            acc_xmin_d = hcnt_q;
            acc_xmax_d = hcnt_q;
            acc_ymin_d = vcnt_q;
            acc_ymax_d = vcnt_q;
          end else begin
            if (hcnt_q < acc_xmin_q) acc_xmin_d = hcnt_q;
            if (hcnt_q > acc_xmax_q) acc_xmax_d = hcnt_q;
            if (vcnt_q < acc_ymin_q) acc_ymin_d = vcnt_q;
            if (vcnt_q > acc_ymax_q) acc_ymax_d = vcnt_q;
          end
          if (acc_count_q != CNT_MAX) begin
            acc_count_d = acc_count_q + CNTW'(1);
          end
        end
        if (frame_end) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        state_d      = WAIT_FRAME;
        stat_valid_d = 1'b1;
        stat_found_d = acc_found_q;
        stat_xmin_d  = acc_xmin_q;
        stat_xmax_d  = acc_xmax_q;
        stat_ymin_d  = acc_ymin_q;
        stat_ymax_d  = acc_ymax_q;
        stat_count_d = acc_count_q;
      end
      default: begin
        state_d = WAIT_FRAME;
      end
    endcase
  end

  // vsync history keeps sampling through reset so a frame already in progress
  // at reset release is not mistaken for a new frame start
  always_ff @(posedge clk) begin
    vsync_prev_q <= vsync_prev_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_FRAME;
      post_vsync_q <= 1'b0;
      post_href_q  <= 1'b0;
      post_bit_q   <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      acc_found_q  <= 1'b0;
      acc_xmin_q   <= '0;
      acc_xmax_q   <= '0;
      acc_ymin_q   <= '0;
      acc_ymax_q   <= '0;
      acc_count_q  <= '0;
      stat_valid_q <= 1'b0;
      stat_found_q <= 1'b0;
      stat_xmin_q  <= '0;
      stat_xmax_q  <= '0;
      stat_ymin_q  <= '0;
      stat_ymax_q  <= '0;
      stat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      post_vsync_q <= post_vsync_d;
      post_href_q  <= post_href_d;
      post_bit_q   <= post_bit_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      acc_found_q  <= acc_found_d;
      acc_xmin_q   <= acc_xmin_d;
      acc_xmax_q   <= acc_xmax_d;
      acc_ymin_q   <= acc_ymin_d;
      acc_ymax_q   <= acc_ymax_d;
      acc_count_q  <= acc_count_d;
      stat_valid_q <= stat_valid_d;
      stat_found_q <= stat_found_d;
      stat_xmin_q  <= stat_xmin_d;
      stat_xmax_q  <= stat_xmax_d;
      stat_ymin_q  <= stat_ymin_d;
      stat_ymax_q  <= stat_ymax_d;
      stat_count_q <= stat_count_d;
    end
  end

  assign post_frame_vsync = post_vsync_q;
  assign post_frame_href  = post_href_q;
  assign post_img_Bit     = post_bit_q;
  assign stat_valid       = stat_valid_q;
  assign stat_found       = stat_found_q;
  assign stat_xmin        = stat_xmin_q;
  assign stat_xmax        = stat_xmax_q;
  assign stat_ymin        = stat_ymin_q;
  assign stat_ymax        = stat_ymax_q;
  assign stat_count       = stat_count_q;

endmodule

// File: tb/tb_edge_bbox_stats.sv
// Bench for edge_bbox_stats (8x6 image): directed frames plus random frames,
// expected stats computed from a bench-side image array.
module tb_edge_bbox_stats;

  localparam int HD = 8;
  localparam int VD = 6;
`ifdef EDGE_BBOX_OVERLAY_EN
  localparam bit OVL_EN = 1'b1;
`else
  localparam bit OVL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_img_Bit = 1'b0;
  logic        post_frame_vsync, post_frame_href, post_img_Bit;
  logic        stat_valid, stat_found;
  logic [10:0] stat_xmin, stat_xmax, stat_ymin, stat_ymax;
  logic [20:0] stat_count;

  edge_bbox_stats #(.IMG_HDISP(11'd8), .IMG_VDISP(11'd6)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href), .per_img_Bit(per_img_Bit),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href), .post_img_Bit(post_img_Bit),
    .stat_valid(stat_valid), .stat_found(stat_found),
    .stat_xmin(stat_xmin), .stat_xmax(stat_xmax), .stat_ymin(stat_ymin), .stat_ymax(stat_ymax),
    .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  bit img [0:15][0:15];
  logic [65:0] m_stats = '0;     // {found,xmin,xmax,ymin,ymax,count} currently held by the DUT
  logic [65:0] pend_stats = '0;  // result expected at the next stat_valid
  int valid_due = 0;
  int ones_cnt = 0;
  bit prev_rst = 1'b1;
  bit prev_vs = 1'b0, prev_hr = 1'b0, prev_bit = 1'b0;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [65:0] pack_stats(input bit f, input int xmn, input int xmx,
                                             input int ymn, input int ymx, input int cnt);
    return {f, 11'(xmn), 11'(xmx), 11'(ymn), 11'(ymx), 21'(cnt)};
  endfunction

  // Expected result of a frame, straight from the image contents
  function automatic logic [65:0] calc_stats(input int w, input int h);
    bit f = 1'b0;
    int xmn = 0, xmx = 0, ymn = 0, ymx = 0, cnt = 0;
    for (int y = 0; y < h && y < VD; y++)
      for (int x = 0; x < w && x < HD; x++)
        if (img[y][x]) begin
          if (!f) begin xmn = x; xmx = x; ymn = y; ymx = y; end
          else begin
            if (x < xmn) xmn = x;
            if (x > xmx) xmx = x;
            if (y < ymn) ymn = y;
            if (y > ymx) ymx = y;
          end
          f = 1'b1;
          cnt++;
        end
    return pack_stats(f, xmn, xmx, ymn, ymx, cnt);
  endfunction

  // Is (x,y) on the border of the box currently reported by the DUT
  function automatic bit on_border(input int x, input int y);
    int xmn = int'(m_stats[64:54]);
    int xmx = int'(m_stats[53:43]);
    int ymn = int'(m_stats[42:32]);
    int ymx = int'(m_stats[31:21]);
    if (!m_stats[65]) return 1'b0;
    return ((x >= xmn && x <= xmx && (y == ymn || y == ymx)) ||
            (y >= ymn && y <= ymx && (x == xmn || x == xmx)));
  endfunction

  // One clock: check outputs produced from the previous cycle's inputs, then drive new inputs
  task automatic tick(input bit r, input bit v, input bit h, input bit b,
                      input bit acc, input int x, input int y);
    bit exp_v;
    @(negedge clk);
    if (prev_rst) begin
      m_stats   = '0;
      valid_due = 0;
    end
    exp_v = (valid_due == 1);
    if (valid_due > 0) valid_due--;
    if (exp_v) m_stats = pend_stats;
    chk("post_vsync", 66'(post_frame_vsync), 66'(prev_vs));
    chk("post_href",  66'(post_frame_href),  66'(prev_hr));
    chk("post_bit",   66'(post_img_Bit),     66'(prev_bit));
    chk("stat_valid", 66'(stat_valid),       66'(exp_v));
    chk("stats", {stat_found, stat_xmin, stat_xmax, stat_ymin, stat_ymax, stat_count}, m_stats);
    ones_cnt += int'(post_img_Bit);
    rst             = r;
    per_frame_vsync = v;
    per_frame_href  = h;
    per_img_Bit     = b;
    prev_rst = r;
    prev_vs  = r ? 1'b0 : v;
    prev_hr  = r ? 1'b0 : h;
    prev_bit = r ? 1'b0 : ((b & h) | (OVL_EN & acc & on_border(x, y)));
  endtask

  // Send one w x h frame from img; optional synchronous reset just before line rst_line
  task automatic run_frame(input int w, input int h, input int rst_line);
    bit aborted = 1'b0;
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int y = 0; y < h; y++) begin
      if (y == rst_line) begin
        tick(1, 1, 0, 0, 0, 0, 0);
        aborted = 1'b1;
      end
      for (int x = 0; x < w; x++) tick(0, 1, 1, img[y][x], !aborted, x, y);
      tick(0, 1, 0, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 0, 0, 0);
    if (!aborted) begin
      pend_stats = calc_stats(w, h);
      valid_due  = 2;
    end
    repeat (4) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_img();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) img[y][x] = 1'b0;
  endtask

  initial begin
    repeat (3) tick(1, 0, 0, 0, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0, 0, 0, 0);

    // single edge
    clear_img(); img[2][3] = 1'b1;
    run_frame(HD, VD, -1);
    chk("t1_stats", m_stats, pack_stats(1'b1, 3, 3, 2, 2, 1));

    // three edges
    clear_img(); img[4][1] = 1'b1; img[1][6] = 1'b1; img[5][5] = 1'b1;
    run_frame(HD, VD, -1);
    chk("t2_stats", m_stats, pack_stats(1'b1, 1, 6, 1, 5, 3));

    // empty frame
    clear_img();
    run_frame(HD, VD, -1);
    chk("t3_stats", m_stats, pack_stats(1'b0, 0, 0, 0, 0, 0));

    // over-wide and over-tall frame, all edges
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) img[y][x] = 1'b1;
    run_frame(10, 8, -1);
    chk("t4_stats", m_stats, pack_stats(1'b1, 0, 7, 0, 5, 48));

    // reset mid-frame, then a frame with an edge at the origin
    clear_img(); img[0][0] = 1'b1; img[3][4] = 1'b1;
    run_frame(HD, VD, 2);
    chk("t5_reset_stats", m_stats, 66'd0);
    clear_img(); img[0][0] = 1'b1;
    run_frame(HD, VD, -1);
    chk("t5_stats", m_stats, pack_stats(1'b1, 0, 0, 0, 0, 1));

    // box (2..5, 1..4), then a blank frame carrying the overlay
    clear_img(); img[1][2] = 1'b1; img[4][5] = 1'b1;
    run_frame(HD, VD, -1);
    clear_img();
    ones_cnt = 0;
    run_frame(HD, VD, -1);
    chk("t6_overlay_ones", 66'(ones_cnt), OVL_EN ? 66'd12 : 66'd0);

    // random frames
    for (int n = 0; n < 20; n++) begin
      int w = int'($urandom_range(11, 5));
      int h = int'($urandom_range(8, 3));
      int dens = int'($urandom_range(30, 0));
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) img[y][x] = ($urandom_range(99, 0) < dens);
      run_frame(w, h, (n % 7 == 3) ? 1 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
